memory_access_unit: RTL and testbench

- Memory-stage consumer of the E->M pipeline register outputs (M_opcode, M_funct, M_valE, M_val2).
- Decodes RV32I loads/stores and runs a req/ack transaction on the data-memory port.
- Returns sign- or zero-extended load data as m_valM_o to the M->W register.
- Raises m_busy_o to the hazard unit, which stalls the pipeline while an access is in flight.

---
 rtl/memory_access_unit.sv | 188 ++++++++++++++++++
 tb/tb_memory_access_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_unit.sv
// Memory-stage load/store unit: decodes RV32I loads/stores, runs one req/ack
// transaction per op on the data-memory port and formats load results.
module memory_access_unit #(
  parameter logic [6:0] LOAD_OP  = 7'b0000011,
  parameter logic [6:0] STORE_OP = 7'b0100011
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  M_opcode_i,
  input  logic [9:0]  M_funct_i,
  input  logic [31:0] M_valE_i,
  input  logic [31:0] M_val2_i,
  input  logic        M_stall_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] m_valM_o,
  output logic        m_busy_o,
  output logic        m_fault_o
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] valm_q, valm_d;

  logic [2:0]  funct3;
  logic [1:0]  off;
  logic        is_load, is_store, is_mem;
  logic        legal_f3, misaligned, fault_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt;
  logic        unused_funct7;

  assign funct3        = M_funct_i[2:0];
  assign off           = M_valE_i[1:0];
  assign unused_funct7 = ^M_funct_i[9:3];
  assign is_load       = (M_opcode_i == LOAD_OP);
  assign is_store      = (M_opcode_i == STORE_OP);
  assign is_mem        = is_load | is_store;

  // Legality and alignment of the incoming op
  always_comb begin
    legal_f3   = 1'b0;
    misaligned = 1'b0;
    if (is_load) begin
      case (funct3)
        3'b000, 3'b100: legal_f3 = 1'b1;
        3'b001, 3'b101: begin legal_f3 = 1'b1; misaligned = off[0]; end
        3'b010:         begin legal_f3 = 1'b1; misaligned = (off != 2'b00); end
        default:        legal_f3 = 1'b0;
      endcase
    end else if (is_store) begin
      case (funct3)
        3'b000:  legal_f3 = 1'b1;
        3'b001:  begin legal_f3 = 1'b1; misaligned = off[0]; end
        3'b010:  begin legal_f3 = 1'b1; misaligned = (off != 2'b00); end
        default: legal_f3 = 1'b0;
      endcase
    end
  end

  assign fault_c = is_mem & (~legal_f3 | misaligned);

  // Store lane placement; loads drive no enables and no data
  always_comb begin
    be_c    = 4'b0000;
    wdata_c = 32'h0;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          be_c    = 4'b0001 << off;
          wdata_c = {4{M_val2_i[7:0]}};
        end
        2'b01: begin
          be_c    = 4'b0011 << off;
          wdata_c = {2{M_val2_i[15:0]}};
        end
        default: begin
          be_c    = 4'b1111;
          wdata_c = M_val2_i;
        end
      endcase
    end
  end

  always_comb begin
    case (off_q)
      2'b00:   byte_sel = dmem_rdata_i[7:0];
      2'b01:   byte_sel = dmem_rdata_i[15:8];
      2'b10:   byte_sel = dmem_rdata_i[23:16];
      default: byte_sel = dmem_rdata_i[31:24];
    endcase
    half_sel = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (funct3_q)
      3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_fmt = {24'h0, byte_sel};
      3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_fmt = {16'h0, half_sel};
      default: load_fmt = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    valm_d   = valm_q;
    unique case (state_q)
      StIdle: begin
        if (is_mem && !fault_c) begin
          state_d  = StReq;
          req_d    = 1'b1;
          we_d     = is_store;
          addr_d   = {M_valE_i[31:2], 2'b00};
          wdata_d  = wdata_c;
          be_d     = be_c;
          funct3_d = funct3;
          off_d    = off;
        end
      end
      StReq: begin
        if (dmem_ack_i) begin
          state_d = StDone;
          req_d   = 1'b0;
          valm_d  = we_q ? 32'h0 : load_fmt;
        end
      end
      StDone: begin
        if (!M_stall_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      be_q     <= 4'b0000;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      valm_q   <= 32'h0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      valm_q   <= valm_d;
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign dmem_be_o    = be_q;
  assign m_valM_o     = valm_q;
  assign m_busy_o     = (state_q == StReq) | ((state_q == StIdle) & is_mem & ~fault_c);
  assign m_fault_o    = (state_q == StIdle) & fault_c;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: loads, stores, faults, stall and reset.
module tb_memory_access_unit;

  localparam logic [6:0] LdOp = 7'b0000011;
  localparam logic [6:0] StOp = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [6:0]  M_opcode_i;
  logic [9:0]  M_funct_i;
  logic [31:0] M_valE_i, M_val2_i;
  logic        M_stall_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] m_valM_o;
  logic        m_busy_o, m_fault_o;

  int checks = 0;
  int passed = 0;

  memory_access_unit dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .M_opcode_i  (M_opcode_i),
    .M_funct_i   (M_funct_i),
    .M_valE_i    (M_valE_i),
    .M_val2_i    (M_val2_i),
    .M_stall_i   (M_stall_i),
    .dmem_req_o  (dmem_req_o),
    .dmem_we_o   (dmem_we_o),
    .dmem_addr_o (dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o),
    .dmem_be_o   (dmem_be_o),
    .dmem_ack_i  (dmem_ack_i),
    .dmem_rdata_i(dmem_rdata_i),
    .m_valM_o    (m_valM_o),
    .m_busy_o    (m_busy_o),
    .m_fault_o   (m_fault_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] v2);
    M_opcode_i = op;
    M_funct_i  = {7'b0, f3};
    M_valE_i   = a;
    M_val2_i   = v2;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (dmem_req_o !== 1'b0) $display("FAIL rst_req got=%0b exp=0", dmem_req_o); else passed++;
    checks++; if (m_valM_o !== 32'h0) $display("FAIL rst_valM got=%h exp=0", m_valM_o); else passed++;
    checks++; if (dmem_be_o !== 4'h0) $display("FAIL rst_be got=%b exp=0000", dmem_be_o); else passed++;
    checks++; if (m_busy_o !== 1'b0) $display("FAIL rst_busy got=%0b exp=0", m_busy_o); else passed++;
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lw;
    drive(LdOp, 3'b010, 32'h100, 32'h0);
    #1;
    checks++; if (m_busy_o !== 1'b1) $display("FAIL lw_busy_idle got=%0b exp=1", m_busy_o); else passed++;
    checks++; if (dmem_req_o !== 1'b0) $display("FAIL lw_req_idle got=%0b exp=0", dmem_req_o); else passed++;
    @(negedge clk);
    checks++; if (dmem_req_o !== 1'b1) $display("FAIL lw_req got=%0b exp=1", dmem_req_o); else passed++;
    checks++; if (dmem_addr_o !== 32'h100) $display("FAIL lw_addr got=%h exp=100", dmem_addr_o); else passed++;
    checks++; if (dmem_be_o !== 4'b0000) $display("FAIL lw_be got=%b exp=0000", dmem_be_o); else passed++;
    checks++; if (dmem_we_o !== 1'b0) $display("FAIL lw_we got=%0b exp=0", dmem_we_o); else passed++;
    checks++; if (m_busy_o !== 1'b1) $display("FAIL lw_busy_req got=%0b exp=1", m_busy_o); else passed++;
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (m_valM_o !== 32'hDEADBEEF) $display("FAIL lw_valM got=%h exp=deadbeef", m_valM_o); else passed++;
    checks++; if (dmem_req_o !== 1'b0) $display("FAIL lw_req_done got=%0b exp=0", dmem_req_o); else passed++;
    checks++; if (m_busy_o !== 1'b0) $display("FAIL lw_busy_done got=%0b exp=0", m_busy_o); else passed++;
    dmem_ack_i = 1'b0; drive(7'h0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (m_valM_o !== 32'hDEADBEEF) $display("FAIL lw_valM_hold got=%h exp=deadbeef", m_valM_o); else passed++;
  endtask

  task automatic test_load_formats;
    logic [2:0]  f3 [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b100, 3'b001};
    logic [31:0] ad [7] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h101, 32'h100};
    logic [31:0] rd [7] = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80FFFFFF, 32'h80FF1234,
                            32'h0000007F, 32'h0000AB00, 32'h0000F00D};
    logic [31:0] ex [7] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF,
                            32'h0000007F, 32'h000000AB, 32'hFFFFF00D};
    for (int i = 0; i < 7; i++) begin
      drive(LdOp, f3[i], ad[i], 32'h0);
      @(negedge clk);
      dmem_ack_i = 1'b1; dmem_rdata_i = rd[i];
      @(negedge clk);
      checks++;
      if (m_valM_o !== ex[i]) $display("FAIL load_fmt[%0d] got=%h exp=%h", i, m_valM_o, ex[i]);
      else passed++;
      dmem_ack_i = 1'b0; drive(7'h0, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
    end
  endtask

  task automatic test_store_delayed;
    drive(StOp, 3'b000, 32'h201, 32'h000000AB);
    @(negedge clk);
    drive(7'h13, 3'b010, 32'hFFF, 32'h55555555);
    for (int i = 0; i < 3; i++) begin
      checks++; if (dmem_req_o !== 1'b1) $display("FAIL sb_req[%0d] got=%0b exp=1", i, dmem_req_o); else passed++;
      checks++; if (dmem_we_o !== 1'b1) $display("FAIL sb_we[%0d] got=%0b exp=1", i, dmem_we_o); else passed++;
      checks++; if (dmem_addr_o !== 32'h200) $display("FAIL sb_addr[%0d] got=%h exp=200", i, dmem_addr_o); else passed++;
      checks++; if (dmem_be_o !== 4'b0010) $display("FAIL sb_be[%0d] got=%b exp=0010", i, dmem_be_o); else passed++;
      checks++; if (dmem_wdata_o !== 32'hABABABAB) $display("FAIL sb_wdata[%0d] got=%h exp=abababab", i, dmem_wdata_o); else passed++;
      checks++; if (m_busy_o !== 1'b1) $display("FAIL sb_busy[%0d] got=%0b exp=1", i, m_busy_o); else passed++;
      @(negedge clk);
    end
    dmem_ack_i = 1'b1;
    @(negedge clk);
    checks++; if (dmem_req_o !== 1'b0) $display("FAIL sb_req_done got=%0b exp=0", dmem_req_o); else passed++;
    checks++; if (m_valM_o !== 32'h0) $display("FAIL sb_valM got=%h exp=0", m_valM_o); else passed++;
    dmem_ack_i = 1'b0; drive(7'h0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_store_lanes;
    logic [2:0]  f3 [3] = '{3'b001, 3'b010, 3'b001};
    logic [31:0] ad [3] = '{32'h202, 32'h300, 32'h400};
    logic [31:0] v2 [3] = '{32'h1234ABCD, 32'h11223344, 32'hFFFF5A5A};
    logic [3:0]  eb [3] = '{4'b1100, 4'b1111, 4'b0011};
    logic [31:0] ew [3] = '{32'hABCDABCD, 32'h11223344, 32'h5A5A5A5A};
    for (int i = 0; i < 3; i++) begin
      drive(StOp, f3[i], ad[i], v2[i]);
      @(negedge clk);
      checks++;
      if (dmem_be_o !== eb[i]) $display("FAIL st_be[%0d] got=%b exp=%b", i, dmem_be_o, eb[i]);
      else passed++;
      checks++;
      if (dmem_wdata_o !== ew[i]) $display("FAIL st_wdata[%0d] got=%h exp=%h", i, dmem_wdata_o, ew[i]);
      else passed++;
      dmem_ack_i = 1'b1;
      @(negedge clk);
      dmem_ack_i = 1'b0; drive(7'h0, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
    end
  endtask

  task automatic test_fault;
    drive(LdOp, 3'b010, 32'h102, 32'h0);
    #1;
    checks++; if (m_fault_o !== 1'b1) $display("FAIL lw_mis_fault got=%0b exp=1", m_fault_o); else passed++;
    checks++; if (m_busy_o !== 1'b0) $display("FAIL lw_mis_busy got=%0b exp=0", m_busy_o); else passed++;
    @(negedge clk);
    checks++; if (dmem_req_o !== 1'b0) $display("FAIL lw_mis_req got=%0b exp=0", dmem_req_o); else passed++;
    checks++; if (m_fault_o !== 1'b1) $display("FAIL lw_mis_stay got=%0b exp=1", m_fault_o); else passed++;
    drive(StOp, 3'b001, 32'h103, 32'h0);
    #1;
    checks++; if (m_fault_o !== 1'b1) $display("FAIL sh_mis_fault got=%0b exp=1", m_fault_o); else passed++;
    drive(LdOp, 3'b011, 32'h100, 32'h0);
    #1;
    checks++; if (m_fault_o !== 1'b1) $display("FAIL f3_011_fault got=%0b exp=1", m_fault_o); else passed++;
    checks++; if (m_busy_o !== 1'b0) $display("FAIL f3_011_busy got=%0b exp=0", m_busy_o); else passed++;
    drive(7'h33, 3'b011, 32'h101, 32'h0);
    #1;
    checks++; if (m_fault_o !== 1'b0) $display("FAIL alu_fault got=%0b exp=0", m_fault_o); else passed++;
    @(negedge clk);
    checks++; if (dmem_req_o !== 1'b0) $display("FAIL fault_no_req got=%0b exp=0", dmem_req_o); else passed++;
    drive(7'h0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_stall;
    drive(LdOp, 3'b010, 32'h400, 32'h0);
    @(negedge clk);
    M_stall_i = 1'b1; dmem_ack_i = 1'b1; dmem_rdata_i = 32'h12345678;
    @(negedge clk);
    dmem_ack_i = 1'b0;
    checks++; if (m_valM_o !== 32'h12345678) $display("FAIL stall_valM got=%h exp=12345678", m_valM_o); else passed++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (dmem_req_o !== 1'b0) $display("FAIL stall_req[%0d] got=%0b exp=0", i, dmem_req_o); else passed++;
      checks++; if (m_busy_o !== 1'b0) $display("FAIL stall_busy[%0d] got=%0b exp=0", i, m_busy_o); else passed++;
    end
    M_stall_i = 1'b0;
    @(negedge clk);
    // Back in IDLE with the held op now treated as a new one
    checks++; if (m_busy_o !== 1'b1) $display("FAIL unstall_busy got=%0b exp=1", m_busy_o); else passed++;
    checks++; if (dmem_req_o !== 1'b0) $display("FAIL unstall_req got=%0b exp=0", dmem_req_o); else passed++;
    @(negedge clk);
    checks++; if (dmem_req_o !== 1'b1) $display("FAIL reissue_req got=%0b exp=1", dmem_req_o); else passed++;
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hCAFEF00D;
    @(negedge clk);
    checks++; if (m_valM_o !== 32'hCAFEF00D) $display("FAIL reissue_valM got=%h exp=cafef00d", m_valM_o); else passed++;
    dmem_ack_i = 1'b0; drive(7'h0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    drive(StOp, 3'b010, 32'h500, 32'h87654321);
    @(negedge clk);
    checks++; if (dmem_req_o !== 1'b1) $display("FAIL rmid_req_pre got=%0b exp=1", dmem_req_o); else passed++;
    rst_i = 1'b1;
    @(negedge clk);
    checks++; if (dmem_req_o !== 1'b0) $display("FAIL rmid_req got=%0b exp=0", dmem_req_o); else passed++;
    checks++; if (dmem_we_o !== 1'b0) $display("FAIL rmid_we got=%0b exp=0", dmem_we_o); else passed++;
    checks++; if (dmem_addr_o !== 32'h0) $display("FAIL rmid_addr got=%h exp=0", dmem_addr_o); else passed++;
    checks++; if (dmem_wdata_o !== 32'h0) $display("FAIL rmid_wdata got=%h exp=0", dmem_wdata_o); else passed++;
    checks++; if (dmem_be_o !== 4'h0) $display("FAIL rmid_be got=%b exp=0000", dmem_be_o); else passed++;
    checks++; if (m_valM_o !== 32'h0) $display("FAIL rmid_valM got=%h exp=0", m_valM_o); else passed++;
    rst_i = 1'b0; drive(7'h0, 3'b000, 32'h0, 32'h0);
    #1;
    checks++; if (m_busy_o !== 1'b0) $display("FAIL bubble_busy got=%0b exp=0", m_busy_o); else passed++;
    checks++; if (m_fault_o !== 1'b0) $display("FAIL bubble_fault got=%0b exp=0", m_fault_o); else passed++;
    @(negedge clk);
    checks++; if (dmem_req_o !== 1'b0) $display("FAIL bubble_req got=%0b exp=0", dmem_req_o); else passed++;
  endtask

  initial begin
    rst_i = 1'b1; M_stall_i = 1'b0; dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
    drive(7'h0, 3'b000, 32'h0, 32'h0);
    test_reset();
    test_lw();
    test_load_formats();
    test_store_delayed();
    test_store_lanes();
    test_fault();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
